// File: rtl/fetch_icache_if.sv
// Request/ready fetch channel between the fetch unit and the instruction cache.
interface fetch_icache_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] data;

  modport master (output req, output addr, input ready, input data);
  modport slave  (input req, input addr, output ready, output data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, handshakes with the I-cache,
// loads the IF/ID register and freezes fetch when it sees HLT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'hE000,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_id_i,
  input  logic          redirect_i,
  input  logic [15:0]   redirect_pc_i,
  fetch_icache_if.master ic,
  output logic [15:0]   pc_out_o,
  output logic          ifid_valid_o,
  output logic [15:0]   ifid_instr_o,
  output logic [15:0]   ifid_pc_plus2_o,
  output logic          halted_o
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pcp2_q, pcp2_d;
  logic [XLEN-1:0]   pc_plus2;

  assign pc_plus2 = pc_q + XLEN'(2);

  // State and IF/ID register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pcp2_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
    end
  end

  // Next-state: redirect > stall > fetch completion.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;

    if (redirect_i) begin
      state_d = S_FETCH;
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (stall_id_i) begin
      // A word returned while stalled is dropped and re-requested later.
      if (state_q == S_FETCH && !ic.ready) begin
        state_d = S_MISS;
      end
    end else if (state_q == S_HALT) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (ic.ready) begin
      valid_d = 1'b1;
      instr_d = ic.data;
      pcp2_d  = pc_plus2;
      if (ic.data[15:12] == HLT_OP) begin
        state_d = S_HALT;
      end else begin
        state_d = S_FETCH;
        pc_d    = pc_plus2;
      end
    end else begin
      state_d = S_MISS;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end
  end

  assign ic.req          = (state_q != S_HALT);
  assign ic.addr         = pc_q;
  assign pc_out_o        = pc_q;
  assign ifid_valid_o    = valid_q;
  assign ifid_instr_o    = instr_q;
  assign ifid_pc_plus2_o = pcp2_q;
  assign halted_o        = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected IF/ID contents are queued when a
// hit is driven and popped when ifid_valid rises.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_out;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        halted;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;

  fetch_icache_if ic_bus ();

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_id_i      (stall_id),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .ic              (ic_bus),
    .pc_out_o        (pc_out),
    .ifid_valid_o    (ifid_valid),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_plus2_o (ifid_pc_plus2),
    .halted_o        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cache contents: opcode 1 with the address folded into the low bits.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return {4'h1, a[11:0] ^ 12'h5A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic drive_hit(input logic [15:0] word);
    ic_bus.ready = 1'b1;
    ic_bus.data  = word;
    sb.push_back('{instr: word, pcp2: pc_out + 16'd2});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ic_bus.ready = 1'b0; ic_bus.data = '0;
    tick(); tick();
    sb.delete();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 16'hE000) begin errors++; $display("FAIL reset_instr got=%h exp=e000", ifid_instr); end
    checks++; if (ifid_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL reset_pcp2 got=%h exp=0000", ifid_pc_plus2); end
    checks++; if (halted !== 1'b0 || ic_bus.req !== 1'b1) begin errors++; $display("FAIL reset_halt_req got=%b/%b exp=0/1", halted, ic_bus.req); end
    rst_n = 1'b1;
  endtask

  task automatic test_hits();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_out !== 16'(2 * i)) begin errors++; $display("FAIL hits_pc[%0d] got=%h exp=%h", i, pc_out, 16'(2 * i)); end
      checks++; if (ic_bus.addr !== pc_out) begin errors++; $display("FAIL hits_addr[%0d] got=%h exp=%h", i, ic_bus.addr, pc_out); end
      checks++; if (ifid_valid !== (i > 0)) begin errors++; $display("FAIL hits_valid[%0d] got=%b exp=%b", i, ifid_valid, i > 0); end
      if (ifid_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL hits_sb[%0d] got=valid exp=empty", i); end
        else begin
          e = sb.pop_front();
          if (ifid_instr !== e.instr || ifid_pc_plus2 !== e.pcp2) begin
            errors++; $display("FAIL hits_ifid[%0d] got=%h/%h exp=%h/%h", i, ifid_instr, ifid_pc_plus2, e.instr, e.pcp2);
          end
        end
      end
      if (i < 3) begin drive_hit(mem(pc_out)); tick(); end
    end
  endtask

  task automatic test_miss();
    do_redirect(16'h0004);
    for (int i = 0; i < 3; i++) begin
      ic_bus.ready = 1'b0;
      if (i > 0) begin
        checks++; if (ic_bus.req !== 1'b1 || ic_bus.addr !== 16'h0004) begin errors++; $display("FAIL miss_req[%0d] got=%b/%h exp=1/0004", i, ic_bus.req, ic_bus.addr); end
      end
      tick();
      checks++; if (ifid_valid !== 1'b0 || pc_out !== 16'h0004) begin errors++; $display("FAIL miss_wait[%0d] got=%b/%h exp=0/0004", i, ifid_valid, pc_out); end
    end
    drive_hit(mem(16'h0004));
    tick();
    checks++; if (pc_out !== 16'h0006) begin errors++; $display("FAIL miss_pc got=%h exp=0006", pc_out); end
    checks++;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL miss_fill got=valid%b exp=valid1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc_plus2 !== 16'h0006) begin
        errors++; $display("FAIL miss_ifid got=%h/%h exp=%h/0006", ifid_instr, ifid_pc_plus2, e.instr);
      end
    end
  endtask

  task automatic test_redirect_stall();
    do_redirect(16'h0010);
    ic_bus.ready = 1'b0;
    tick();
    stall_id = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    stall_id = 1'b0; redirect = 1'b0;
    checks++; if (pc_out !== 16'h0100) begin errors++; $display("FAIL rdst_pc got=%h exp=0100", pc_out); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'hE000) begin errors++; $display("FAIL rdst_flush got=%b/%h exp=0/e000", ifid_valid, ifid_instr); end
    drive_hit(mem(16'h0100));
    tick();
    checks++;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rdst_fetch got=valid%b exp=valid1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc_plus2 !== 16'h0102) begin
        errors++; $display("FAIL rdst_ifid got=%h/%h exp=%h/0102", ifid_instr, ifid_pc_plus2, e.instr);
      end
    end
    do_redirect(16'h0101);
    checks++; if (pc_out !== 16'h0101) begin errors++; $display("FAIL odd_redirect got=%h exp=0101", pc_out); end
  endtask

  task automatic test_stall();
    do_redirect(16'h001E);
    drive_hit(mem(16'h001E));
    tick();
    e = sb.pop_front();
    checks++; if (ifid_instr !== e.instr || ifid_pc_plus2 !== 16'h0020) begin errors++; $display("FAIL stall_pre got=%h/%h exp=%h/0020", ifid_instr, ifid_pc_plus2, e.instr); end
    for (int i = 0; i < 2; i++) begin
      stall_id = 1'b1;
      ic_bus.ready = 1'b1; ic_bus.data = mem(16'h0020);
      tick();
      checks++;
      if (pc_out !== 16'h0020 || ifid_valid !== 1'b1 || ifid_instr !== mem(16'h001E) || ifid_pc_plus2 !== 16'h0020) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%h/%h exp=0020/1/%h/0020", i, pc_out, ifid_valid, ifid_instr, ifid_pc_plus2, mem(16'h001E));
      end
    end
    stall_id = 1'b0;
    drive_hit(mem(16'h0020));
    tick();
    e = sb.pop_front();
    checks++; if (pc_out !== 16'h0022 || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pcp2) begin
      errors++; $display("FAIL stall_resume got=%h/%h/%h exp=0022/%h/%h", pc_out, ifid_instr, ifid_pc_plus2, e.instr, e.pcp2);
    end
  endtask

  task automatic test_halt();
    do_redirect(16'h0030);
    drive_hit(16'hF000);
    tick();
    e = sb.pop_front();
    checks++; if (halted !== 1'b1 || pc_out !== 16'h0030 || ic_bus.req !== 1'b0) begin errors++; $display("FAIL halt_enter got=%b/%h/%b exp=1/0030/0", halted, pc_out, ic_bus.req); end
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== e.instr || ifid_pc_plus2 !== 16'h0032) begin errors++; $display("FAIL halt_word got=%b/%h/%h exp=1/f000/0032", ifid_valid, ifid_instr, ifid_pc_plus2); end
    ic_bus.data = mem(16'h0030);
    tick();
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'hE000 || halted !== 1'b1 || pc_out !== 16'h0030) begin
      errors++; $display("FAIL halt_bubble got=%b/%h/%b/%h exp=0/e000/1/0030", ifid_valid, ifid_instr, halted, pc_out);
    end
    do_redirect(16'h0040);
    checks++; if (halted !== 1'b0 || pc_out !== 16'h0040 || ic_bus.req !== 1'b1) begin errors++; $display("FAIL halt_exit got=%b/%h/%b exp=0/0040/1", halted, pc_out, ic_bus.req); end
    drive_hit(mem(16'h0040));
    tick();
    e = sb.pop_front();
    checks++; if (pc_out !== 16'h0042 || ifid_instr !== e.instr || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_refetch got=%h/%h exp=0042/%h", pc_out, ifid_instr, e.instr); end
  endtask

  task automatic test_wrap();
    do_redirect(16'hFFFE);
    drive_hit(mem(16'hFFFE));
    tick();
    e = sb.pop_front();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc_out); end
    checks++; if (ifid_pc_plus2 !== 16'h0000 || ifid_instr !== e.instr) begin errors++; $display("FAIL wrap_ifid got=%h/%h exp=%h/0000", ifid_instr, ifid_pc_plus2, e.instr); end
  endtask

  task automatic test_reset_miss();
    do_redirect(16'h0050);
    drive_hit(mem(16'h0050));
    tick();
    e = sb.pop_front();
    ic_bus.ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (pc_out !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL rstmiss_pc got=%h/%b exp=0000/0", pc_out, halted); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'hE000 || ifid_pc_plus2 !== 16'h0000) begin
      errors++; $display("FAIL rstmiss_ifid got=%b/%h/%h exp=0/e000/0000", ifid_valid, ifid_instr, ifid_pc_plus2);
    end
    drive_hit(mem(16'h0000));
    tick();
    e = sb.pop_front();
    checks++; if (pc_out !== 16'h0002 || ifid_instr !== e.instr || ifid_pc_plus2 !== 16'h0002) begin
      errors++; $display("FAIL rstmiss_fetch got=%h/%h/%h exp=0002/%h/0002", pc_out, ifid_instr, ifid_pc_plus2, e.instr);
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_redirect_stall();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_miss();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the 16-bit pipelined core.
- Owns the program counter and computes next-PC: sequential +2, branch redirect, or hold.
- Runs a request/ready handshake with the instruction cache and tolerates multi-cycle misses.
- Loads the IF/ID pipeline register and detects HLT to freeze fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'hE000, instruction word injected into IF/ID on flush, bubble or halt.
- HLT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- stall_id  input  1  hazard unit: 1 = hold PC and IF/ID.
- redirect  input  1  taken branch/jump resolved in ID.
- redirect_pc  input  16  target address when redirect=1.
- icache_req  output  1  fetch request to I-cache.
- icache_addr  output  16  fetch address (always equals pc_out).
- icache_ready  input  1  1 = icache_data valid this cycle (hit or fill complete).
- icache_data  input  16  instruction word.
- pc_out  output  16  current PC.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  16  IF/ID instruction.
- ifid_pc_plus2  output  16  IF/ID PC+2 of that instruction.
- halted  output  1  fetch frozen on HLT.

Behaviour:
- Reset (rst_n=0 at an edge), from any state, mid-miss included:
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc_plus2=16'h0000, halted=0.
- Reset takes priority over all other inputs.
- States: FETCH, MISS, HALT.
- icache_req=1 in FETCH and MISS; icache_req=0 in HALT. icache_addr=pc combinationally.
- A "fetch completes" when state is FETCH or MISS and icache_ready=1; the instruction word is icache_data.
- Priority at each edge is redirect > stall_id > fetch completion.
- redirect=1, any state:
  - pc<=redirect_pc, state<=FETCH.
  - IF/ID flushed: valid=0, instr=NOP_WORD, pc_plus2 unchanged.
  - Any outstanding miss is abandoned; the address changes on the next cycle and the cache must accept it.
  - stall_id is ignored in this cycle.
- stall_id=1, no redirect:
  - pc and IF/ID hold.
  - FETCH with icache_ready=0 goes to MISS; otherwise state holds.
  - A word returned during a stall is discarded and re-requested later (cache re-hit).
- Fetch completes with no stall and no redirect:
  - IF/ID <= {valid=1, icache_data, pc+2}.
  - If icache_data[15:12]==HLT_OP: pc holds, state<=HALT.
  - Otherwise pc<=pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000); state<=FETCH.
- FETCH with icache_ready=0 and no redirect/stall:
  - state<=MISS, pc holds.
  - IF/ID <= bubble (valid=0, instr=NOP_WORD).
- MISS with icache_ready=0 and no redirect/stall: state holds, pc holds, IF/ID <= bubble.
- HALT:
  - halted=1 combinationally from state.
  - With no stall and no redirect, IF/ID <= bubble. With stall_id=1, IF/ID holds so the HLT word can drain.
  - Leaving HALT requires redirect or reset.
- Single-cycle hit latency: address issued in cycle N, word visible on ifid_* in cycle N+1.
- pc bit 0 is never forced. An odd redirect_pc is passed through unchanged.

Test Plan:
- Reset then continuous hits (ready=1, distinct words at 0,2,4):
  - pc_out reads 0,2,4,6 on successive cycles.
  - ifid_instr follows one cycle behind.
  - ifid_pc_plus2 reads 2,4,6. ifid_valid=0 on the first cycle after reset, then 1.
- Miss of 3 cycles at pc=0x0004:
  - icache_req stays 1, icache_addr=0x0004 and ifid_valid=0 for 3 cycles.
  - On ready: ifid_instr=word, ifid_pc_plus2=0x0006, pc=0x0006.
- Redirect with stall during a miss at pc=0x0010: redirect=1, redirect_pc=0x0100, stall_id=1 in the same cycle.
  - Next cycle: pc=0x0100, state FETCH, ifid_valid=0, ifid_instr=0xE000.
- Stall while hitting at pc=0x0020, stall_id=1 for 2 cycles.
  - pc and ifid_* unchanged for both cycles; resumes at 0x0022 afterwards.
- Fetch 0xF000 at pc=0x0030:
  - halted=1, pc stays 0x0030, icache_req=0, ifid_instr=0xF000 for one cycle, then bubble.
  - Later redirect to 0x0040 clears halted and fetches 0x0040.
- Two edge cases:
  - pc=0xFFFE hit: next pc=0x0000.
  - rst_n=0 during MISS: next cycle pc=RESET_PC, state FETCH, outputs at reset values.
